// File: rtl/mem_wb_pkg.sv
// Shared constants, state encoding and lane helpers for the memory/writeback stage.
package mem_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // sz is funct3[1:0]: 0=byte, 1=half, 2=word; offending low bits are dropped
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = |a;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extractor: picks the byte/half lane and sign- or zero-extends it.
module mem_load_align
  import mem_wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*off_i +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback stage: dmem req/gnt/rvalid handshake and one-cycle regfile write.
// Optional build macro MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic            in_alu_wb,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_sdata,
  input  logic [4:0]      in_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            bus_err,
  output logic            misalign
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            accept, mem_op, trap, timeout_hit;
  logic [1:0]      in_off;

  logic            load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] load_val;

  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic [3:0]      dmem_wstrb_q, dmem_wstrb_d;
  logic            rf_we_q, rf_we_d, bus_err_q, bus_err_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  assign accept  = in_valid & in_ready;
  assign mem_op  = in_load | in_store;
  assign in_off  = lane_off(in_funct3[1:0], in_addr[1:0]);
  assign cnt_inc = cnt_q + TO_W'(1);
  // Error fires on the cycle the counter would reach TIMEOUT: exactly TIMEOUT waiting cycles.
  assign timeout_hit = (cnt_inc == TO_W'(TIMEOUT));

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap = mem_op & is_misaligned(in_funct3[1:0], in_addr[1:0]);
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) misalign_q <= 1'b0;
    else       misalign_q <= accept & trap;
  end
  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  mem_load_align u_align (
    .rdata_i  (dmem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (load_val)
  );

  // ---- state register ----
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = '0;
        state_d = (mem_op && !trap) ? S_REQ : S_WB;
      end
      S_REQ: begin
        if (dmem_gnt) begin
          cnt_d   = '0;
          state_d = load_q ? S_RESP : S_IDLE;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          cnt_d   = '0;
          state_d = S_WB;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- registered output next-values ----
  always_comb begin
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wstrb_d = dmem_wstrb_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_rd_d      = rf_rd_q;
    rf_wd_d      = rf_wd_q;
    rf_we_d      = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        dmem_we_d    = in_store;
        dmem_addr_d  = {in_addr[XLEN-1:2], 2'b00};
        dmem_wstrb_d = in_store ? store_strb(in_funct3[1:0], in_off) : 4'b0000;
        dmem_wdata_d = in_store ? store_data(in_funct3[1:0], in_sdata) : '0;
        if (!mem_op && in_alu_wb) begin
          rf_rd_d = in_rd;
          rf_wd_d = in_addr;
          rf_we_d = (in_rd != 5'd0);
        end
      end
      S_REQ:  bus_err_d = !dmem_gnt && timeout_hit;
      S_RESP: begin
        bus_err_d = !dmem_rvalid && timeout_hit;
        if (dmem_rvalid) begin
          rf_rd_d = rd_q;
          rf_wd_d = load_val;
          rf_we_d = (rd_q != 5'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wstrb_q <= '0;
      dmem_wdata_q <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_wdata_q <= dmem_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wd_q      <= rf_wd_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Op fields only matter between accept and retirement, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      load_q   <= in_load;
      funct3_q <= in_funct3;
      off_q    <= in_off;
      rd_q     <= in_rd;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign dmem_wdata = dmem_wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wd      = rf_wd_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage with a byte-lane reference model.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 255;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b1;
  logic        in_valid, in_ready, in_load, in_store, in_alu_wb;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_sdata;
  logic [4:0]  in_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        rf_we, bus_err, misalign;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.XLEN(32), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_alu_wb(in_alu_wb), .in_funct3(in_funct3), .in_addr(in_addr), .in_sdata(in_sdata),
    .in_rd(in_rd), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_wd(rf_wd), .bus_err(bus_err), .misalign(misalign)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int off_of(input logic [2:0] f3, input logic [31:0] a);
    int lo = int'(a % 4);
    return lo - (lo % size_of(f3));
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int          sz = size_of(f3);
    logic [31:0] v  = w >> (8 * off_of(f3, a));
    if (sz == 1) v = v % 256;
    if (sz == 2) v = v % 65536;
    if (f3 == 3'b000 && v >= 128)   v = v - 256;
    if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    int m = ((1 << size_of(f3)) - 1) << off_of(f3, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size_of(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] aligned(input logic [2:0] f3, input logic [31:0] a);
    return a - (a % size_of(f3));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_alu_wb = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 600) begin step(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_wait_ready in_ready=%b expected 1", tag, in_ready);
    end
  endtask

  task automatic run_alu(input logic [4:0] rd, input logic [31:0] val, input logic wb);
    logic exp_we = wb && (rd != 5'd0);
    wait_ready("alu");
    in_valid = 1'b1; in_alu_wb = wb; in_addr = val; in_rd = rd;
    in_funct3 = 3'($urandom); in_sdata = $urandom;
    step();
    idle_inputs();
    checks++;
    if (rf_we !== exp_we) begin errors++; $display("FAIL alu_we rf_we=%b expected %b", rf_we, exp_we); end
    if (exp_we) begin
      checks++;
      if (rf_rd !== rd || rf_wd !== val) begin
        errors++; $display("FAIL alu_data rd=%0d wd=%h expected rd=%0d wd=%h", rf_rd, rf_wd, rd, val);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL alu_busy in_ready=%b expected 0", in_ready); end
    step();
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL alu_retire rf_we=%b in_ready=%b expected 0/1", rf_we, in_ready);
    end
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] w, input int gd, input int rv);
    logic        bad_we = 1'b0;
    logic [31:0] ev = exp_load(f3, a, w);
    wait_ready("load");
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = f3; in_addr = a; in_rd = rd; in_sdata = $urandom;
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {a[31:2], 2'b00} || misalign !== 1'b0) begin
      errors++; $display("FAIL load_req req=%b we=%b addr=%h mis=%b expected 1/0/%h/0",
                         dmem_req, dmem_we, dmem_addr, misalign, {a[31:2], 2'b00});
    end
    repeat (gd) begin bad_we |= rf_we; step(); end
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL load_req_hold req=%b expected 1", dmem_req); end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop req=%b expected 0", dmem_req); end
    repeat (rv) begin bad_we |= rf_we; step(); end
    dmem_rvalid = 1'b1; dmem_rdata = w; bad_we |= rf_we;
    step();
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    checks++;
    if (bad_we !== 1'b0) begin errors++; $display("FAIL load_early_we saw=%b expected 0", bad_we); end
    checks++;
    if (rf_we !== (rd != 5'd0)) begin errors++; $display("FAIL load_we rf_we=%b expected %b", rf_we, rd != 5'd0); end
    if (rd != 5'd0) begin
      checks++;
      if (rf_rd !== rd || rf_wd !== ev) begin
        errors++; $display("FAIL load_data f3=%0d a=%h rd=%0d wd=%h expected rd=%0d wd=%h",
                           f3, a, rf_rd, rf_wd, rd, ev);
      end
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL load_retire rf_we=%b in_ready=%b expected 0/1", rf_we, in_ready);
    end
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input int gd);
    logic bad_we = 1'b0;
    wait_ready("store");
    in_valid = 1'b1; in_store = 1'b1; in_funct3 = f3; in_addr = a; in_sdata = d;
    in_rd = 5'($urandom_range(1, 31));
    step();
    idle_inputs();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {a[31:2], 2'b00}) begin
      errors++; $display("FAIL store_req req=%b we=%b addr=%h expected 1/1/%h", dmem_req, dmem_we, dmem_addr, {a[31:2], 2'b00});
    end
    checks++;
    if (dmem_wstrb !== exp_strb(f3, a) || dmem_wdata !== exp_wdata(f3, d)) begin
      errors++; $display("FAIL store_lanes strb=%b wdata=%h expected %b %h",
                         dmem_wstrb, dmem_wdata, exp_strb(f3, a), exp_wdata(f3, d));
    end
    repeat (gd) begin bad_we |= rf_we; step(); end
    dmem_gnt = 1'b1; bad_we |= rf_we;
    step();
    dmem_gnt = 1'b0; bad_we |= rf_we;
    checks++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0 || bad_we !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL store_done ready=%b req=%b we_seen=%b err=%b expected 1/0/0/0",
                         in_ready, dmem_req, bad_we, bus_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    in_funct3 = 3'd0; in_addr = '0; in_sdata = '0; in_rd = '0; dmem_rdata = '0;
    RST_X = 1'b1;
    repeat (3) step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready in_ready=%b expected 1", in_ready); end
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, rf_we, rf_rd, rf_wd, bus_err, misalign} !== '0) begin
      errors++; $display("FAIL reset_outputs req=%b we=%b addr=%h strb=%b rf_we=%b rd=%0d wd=%h err=%b mis=%b expected all 0",
                         dmem_req, dmem_we, dmem_addr, dmem_wstrb, rf_we, rf_rd, rf_wd, bus_err, misalign);
    end
    RST_X = 1'b0;
    step();
  endtask

  task automatic test_alu();
    run_alu(5'd5, 32'h0000_1234, 1'b1);
    run_alu(5'd0, 32'hCAFE_0001, 1'b1);
    run_alu(5'd9, 32'h1111_2222, 1'b0);
    for (int i = 0; i < 6; i++) run_alu(5'($urandom), $urandom, 1'b1);
  endtask

  task automatic test_load();
    run_load(F3_LB(),  32'h0000_0103, 5'd3, 32'h80FF_0000, 2, 1);
    run_load(F3_LBU(), 32'h0000_0103, 5'd4, 32'h80FF_0000, 2, 1);
    run_load(3'b001,   32'h0000_0202, 5'd6, 32'h9ABC_1234, 0, 0);
    run_load(3'b101,   32'h0000_0202, 5'd7, 32'h9ABC_1234, 1, 3);
    run_load(3'b010,   32'h0000_0300, 5'd8, 32'h1357_9BDF, 0, 2);
  endtask

  function automatic logic [2:0] F3_LB();  return 3'b000; endfunction
  function automatic logic [2:0] F3_LBU(); return 3'b100; endfunction

  task automatic test_store();
    run_store(3'b001, 32'h0000_0102, 32'h0000_ABCD, 0);
    run_store(3'b000, 32'h0000_0041, 32'h0000_00A5, 2);
    run_store(3'b000, 32'h0000_0043, 32'h1234_5678, 1);
    run_store(3'b010, 32'h0000_0080, 32'hDEAD_BEEF, 3);
  endtask

  task automatic test_rd0();
    run_load(3'b010, 32'h0000_0010, 5'd0, 32'hDEAD_BEEF, 1, 1);
  endtask

  task automatic test_timeout();
    logic bad_we = 1'b0;
    wait_ready("timeout");
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h40; in_rd = 5'd12;
    step();
    idle_inputs();
    repeat (TIMEOUT - 1) begin bad_we |= rf_we; step(); end
    checks++;
    if (bus_err !== 1'b0 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL gnt_timeout_early err=%b req=%b expected 0/1", bus_err, dmem_req);
    end
    step();
    checks++;
    if (bus_err !== 1'b1 || in_ready !== 1'b1 || dmem_req !== 1'b0 || bad_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL gnt_timeout err=%b ready=%b req=%b we=%b/%b expected 1/1/0/0/0",
                         bus_err, in_ready, dmem_req, bad_we, rf_we);
    end
    step();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL gnt_timeout_pulse err=%b expected 0", bus_err); end
    // rvalid never arrives after gnt
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h44; in_rd = 5'd13;
    step();
    idle_inputs();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    repeat (TIMEOUT - 1) step();
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL rv_timeout_early err=%b expected 0", bus_err); end
    step();
    checks++;
    if (bus_err !== 1'b1 || in_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL rv_timeout err=%b ready=%b we=%b expected 1/1/0", bus_err, in_ready, rf_we);
    end
    step();
    // gnt on the last permitted cycle still wins over the timeout
    in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b010; in_addr = 32'h48; in_sdata = 32'h5;
    step();
    idle_inputs();
    repeat (TIMEOUT - 1) step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    checks++;
    if (bus_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL late_gnt err=%b ready=%b expected 0/1", bus_err, in_ready);
    end
  endtask

  task automatic test_ignore();
    logic bad = 1'b0;
    wait_ready("ignore");
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin step(); bad |= rf_we | dmem_req | ~in_ready | bus_err; end
    idle_inputs();
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL idle_ignore seen=%b expected 0", bad); end
    in_valid = 1'b1; in_alu_wb = 1'b1; in_addr = 32'h77; in_rd = 5'd2;
    step();
    idle_inputs();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL wb_ignore we=%b ready=%b req=%b expected 0/1/0", rf_we, in_ready, dmem_req);
    end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    wait_ready("misalign");
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h102; in_rd = 5'd5;
    step();
    idle_inputs();
    checks++;
    if (misalign !== 1'b1 || dmem_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL trap_lw mis=%b req=%b we=%b expected 1/0/0", misalign, dmem_req, rf_we);
    end
    step();
    checks++;
    if (misalign !== 1'b0 || dmem_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL trap_lw_after mis=%b req=%b we=%b expected 0/0/0", misalign, dmem_req, rf_we);
    end
    wait_ready("misalign_sh");
    in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b001; in_addr = 32'h101; in_sdata = 32'h1;
    step();
    idle_inputs();
    checks++;
    if (misalign !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL trap_sh mis=%b req=%b expected 1/0", misalign, dmem_req);
    end
    wait_ready("misalign_end");
`else
    run_load(3'b010, 32'h0000_0102, 5'd5, 32'hA1B2_C3D4, 0, 0);
    run_load(3'b001, 32'h0000_0103, 5'd6, 32'h8001_0000, 1, 0);
    run_store(3'b010, 32'h0000_0101, 32'h0102_0304, 0);
    run_store(3'b001, 32'h0000_0203, 32'h0000_BEEF, 0);
`endif
  endtask

  task automatic test_reset_abort();
    wait_ready("abort");
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h40; in_rd = 5'd9;
    step();
    idle_inputs();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1 RST_X = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || dmem_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL async_reset ready=%b req=%b we=%b expected 1/0/0", in_ready, dmem_req, rf_we);
    end
    step();
    RST_X = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL late_rvalid we=%b ready=%b expected 0/1", rf_we, in_ready);
    end
    step();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL late_rvalid_after we=%b expected 0", rf_we); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: run_alu(5'($urandom), $urandom, 1'($urandom));
        1: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          run_load(f3, aligned(f3, $urandom), 5'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
        default: begin
          f3 = 3'($urandom_range(0, 2));
          run_store(f3, aligned(f3, $urandom), $urandom, $urandom_range(0, 3));
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_rd0();
    test_timeout();
    test_ignore();
    test_misalign();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
